mac_acc_24: RTL and testbench

//  Downstream accumulator stage for the subarray MAC. Consumes one signed 24-bit partial sum
//  per beat from the subarray adder tree and accumulates ACC_LEN beats into a 24-bit register.
//  The register feeds back through CLA_24. The final sum is presented on a valid/ready

---
 rtl/mac_pkg.sv | 14 +
 rtl/mac_acc_24_cla.sv | 47 ++++
 rtl/mac_acc_24.sv | 109 ++++++++++
 tb/tb_mac_acc_24.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the mac_acc_24 accumulator stage.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          MAC_DATA_W  = 24;
    localparam logic [23:0] MAC_SAT_MAX = 24'h7FFFFF;
    localparam logic [23:0] MAC_SAT_MIN = 24'h800000;

endpackage

// File: rtl/mac_acc_24_cla.sv
// 24-bit carry-lookahead adder: 4-bit lookahead blocks chained by group generate/propagate.
module cla_24
    import mac_pkg::*;
(
    input  logic [MAC_DATA_W-1:0] a,
    input  logic [MAC_DATA_W-1:0] b,
    input  logic                  cin,
    output logic [MAC_DATA_W-1:0] sum,
    output logic                  cout
);

    logic [23:0] g;
    logic [23:0] p;
    logic [23:0] carry;
    logic [6:0]  blk_c;
    logic [5:0]  grp_g;
    logic [5:0]  grp_p;

    always_comb begin
        g     = a & b;
        p     = a ^ b;
        carry = '0;
        blk_c = '0;
        grp_g = '0;
        grp_p = '0;
        blk_c[0] = cin;
        for (int k = 0; k < 6; k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
            blk_c[k+1] = grp_g[k] | (grp_p[k] & blk_c[k]);
            // Carries inside a block are expanded from the block carry-in only.
            carry[4*k]   = blk_c[k];
            carry[4*k+1] = g[4*k] | (p[4*k] & blk_c[k]);
            carry[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                         | (p[4*k+1] & p[4*k] & blk_c[k]);
            carry[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                         | (p[4*k+2] & p[4*k+1] & g[4*k])
                         | (p[4*k+2] & p[4*k+1] & p[4*k] & blk_c[k]);
        end
        sum  = p ^ carry;
        cout = blk_c[6];
    end

endmodule

// File: rtl/mac_acc_24.sv
// Accumulates ACC_LEN signed 24-bit partial sums and offers the total on a valid/ready port.
// Optional build macro MAC_ACC_SAT_EN: saturate instead of wrapping on signed overflow.
module mac_acc_24
    import mac_pkg::*;
#(
    parameter int ACC_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MAC_DATA_W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MAC_DATA_W-1:0] out_data,
    output logic                  out_ovf
);

    localparam int             CNT_W = $clog2(ACC_LEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN);

    // Handshake: a beat moves when in_valid && in_ready; a result moves when
    // out_valid && out_ready. Neither side's valid depends on the other's ready.
    state_t                state;
    state_t                state_next;
    logic [MAC_DATA_W-1:0] acc;
    logic [MAC_DATA_W-1:0] a_sel;
    logic [MAC_DATA_W-1:0] sum;
    logic [MAC_DATA_W-1:0] acc_next;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  ovf;
    logic                  add_ovf;
    logic                  beat;
    logic                  cla_cout_unused;

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign out_data  = acc;
    assign out_ovf   = ovf;
    assign beat      = in_valid && in_ready;
    assign cnt_inc   = cnt + CNT_W'(1);

    // The first beat of a window starts from zero rather than the stale register.
    assign a_sel = (state == IDLE) ? '0 : acc;

    cla_24 u_cla (
        .a    (a_sel),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cla_cout_unused)
    );

    assign add_ovf = (a_sel[23] == in_data[23]) && (sum[23] != a_sel[23]);

`ifdef MAC_ACC_SAT_EN
    assign acc_next = add_ovf ? (a_sel[23] ? MAC_SAT_MIN : MAC_SAT_MAX) : sum;
`else
    assign acc_next = sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (beat) begin
                        state_next = (cnt_inc == LAST) ? DONE : ACC;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr || (out_valid && out_ready)) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (beat) begin
            acc <= acc_next;
            cnt <= cnt_inc;
            ovf <= ovf | add_ovf;
        end
    end

endmodule

// File: tb/tb_mac_acc_24.sv
// Directed bench for mac_acc_24 with ACC_LEN=4: vector table plus hand-written corner sequences.
module tb_mac_acc_24;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        out_ovf;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0][23:0] d;
        logic [23:0]      exp_data;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[7];

    mac_acc_24 #(.ACC_LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic [23:0] a, input logic [23:0] b,
                                input logic [23:0] c, input logic [23:0] e,
                                input logic [23:0] x, input logic o);
        vec_t v;
        v.d[0] = a;
        v.d[1] = b;
        v.d[2] = c;
        v.d[3] = e;
        v.exp_data = x;
        v.exp_ovf  = o;
        return v;
    endfunction

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; presents one beat across the next rising edge.
    task automatic send(input logic [23:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_window(input vec_t v, input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk({name, " in_ready"}, {23'd0, in_ready}, 24'd1);
            chk({name, " early out_valid"}, {23'd0, out_valid}, 24'd0);
            send(v.d[i]);
        end
        chk({name, " out_valid"}, {23'd0, out_valid}, 24'd1);
        chk({name, " out_data"}, out_data, v.exp_data);
        chk({name, " out_ovf"}, {23'd0, out_ovf}, {23'd0, v.exp_ovf});
        @(negedge clk);
        chk({name, " out_valid one cycle"}, {23'd0, out_valid}, 24'd0);
        chk({name, " cleared"}, out_data, 24'd0);
    endtask

    initial begin
        vecs[0] = mk(24'd1, 24'd2, 24'd3, 24'd4, 24'd10, 1'b0);
        vecs[1] = mk(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFC, 1'b0);
        vecs[5] = mk(24'h000064, 24'hFFFFCE, 24'hFFFFC4, 24'h000007, 24'hFFFFFD, 1'b0);
`ifdef MAC_ACC_SAT_EN
        vecs[2] = mk(24'h7FFFFF, 24'd1, 24'd0, 24'd0, 24'h7FFFFF, 1'b1);
        vecs[3] = mk(24'h800000, 24'hFFFFFF, 24'd0, 24'd0, 24'h800000, 1'b1);
        vecs[4] = mk(24'h7FFFFF, 24'd1, 24'hFFFFFF, 24'd0, 24'h7FFFFE, 1'b1);
        vecs[6] = mk(24'h400000, 24'h400000, 24'hFFFFFF, 24'd1, 24'h7FFFFF, 1'b1);
`else
        vecs[2] = mk(24'h7FFFFF, 24'd1, 24'd0, 24'd0, 24'h800000, 1'b1);
        vecs[3] = mk(24'h800000, 24'hFFFFFF, 24'd0, 24'd0, 24'h7FFFFF, 1'b1);
        vecs[4] = mk(24'h7FFFFF, 24'd1, 24'hFFFFFF, 24'd0, 24'h7FFFFF, 1'b1);
        vecs[6] = mk(24'h400000, 24'h400000, 24'hFFFFFF, 24'd1, 24'h800000, 1'b1);
`endif

        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset in_ready", {23'd0, in_ready}, 24'd1);
        chk("reset out_valid", {23'd0, out_valid}, 24'd0);
        chk("reset out_data", out_data, 24'd0);
        chk("reset out_ovf", {23'd0, out_ovf}, 24'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_window(vecs[i], $sformatf("vec%0d", i));
        end

        // Result held under back-pressure while a beat waits upstream.
        out_ready = 1'b0;
        send(24'h7FFFFF);
        send(24'd1);
        send(24'd0);
        send(24'd0);
        in_valid = 1'b1;
        in_data  = 24'd9;
        for (int k = 0; k < 5; k++) begin
            chk("hold out_valid", {23'd0, out_valid}, 24'd1);
            chk("hold in_ready", {23'd0, in_ready}, 24'd0);
            chk("hold out_data", out_data, vecs[2].exp_data);
            chk("hold out_ovf", {23'd0, out_ovf}, 24'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold release out_valid", {23'd0, out_valid}, 24'd0);
        chk("hold release out_data", out_data, 24'd0);
        chk("hold release out_ovf", {23'd0, out_ovf}, 24'd0);
        run_window(mk(24'd1, 24'd1, 24'd1, 24'd1, 24'd4, 1'b0), "after_hold");

        // Abort after two beats; the beat presented alongside clr is dropped.
        send(24'd5);
        send(24'd5);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 24'd5;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr out_data", out_data, 24'd0);
        chk("clr in_ready", {23'd0, in_ready}, 24'd1);
        chk("clr out_valid", {23'd0, out_valid}, 24'd0);
        run_window(mk(24'd5, 24'd5, 24'd5, 24'd5, 24'd20, 1'b0), "after_clr");

        // Abort a pending result.
        out_ready = 1'b0;
        send(24'd1);
        send(24'd2);
        send(24'd3);
        send(24'd4);
        chk("clr_done pending", {23'd0, out_valid}, 24'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_done out_valid", {23'd0, out_valid}, 24'd0);
        chk("clr_done out_data", out_data, 24'd0);
        run_window(vecs[0], "after_clr_done");

        // Asynchronous reset mid-window, checked before the next rising edge.
        send(24'h7FFFFF);
        send(24'd1);
        chk("mid ovf set", {23'd0, out_ovf}, 24'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async mid out_data", out_data, 24'd0);
        chk("async mid out_ovf", {23'd0, out_ovf}, 24'd0);
        chk("async mid in_ready", {23'd0, in_ready}, 24'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_window(vecs[0], "after_rst_mid");

        // Asynchronous reset while a result is pending.
        out_ready = 1'b0;
        send(24'd3);
        send(24'd3);
        send(24'd3);
        send(24'd3);
        chk("rst_done pending data", out_data, 24'd12);
        #2 rst_n = 1'b0;
        #1;
        chk("async done out_valid", {23'd0, out_valid}, 24'd0);
        chk("async done out_data", out_data, 24'd0);
        chk("async done in_ready", {23'd0, in_ready}, 24'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_window(vecs[5], "after_rst_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
